// File: rtl/io_irq_timer.sv
// ============================================================================
//  Module   : io_irq_timer
//  Purpose  : Port-side interrupt/timer peripheral. Receives a command byte and
//             a data byte from CPU output ports. Merges three asynchronous
//             rising-edge interrupt sources and an internal down-counting timer
//             (source 3) into a masked, prioritised, level interrupt. Status
//             and vector bytes are returned on CPU input ports.
//  Ports    : clk      - system clock, rising edge
//             reset    - asynchronous, active-low reset
//             cmd      - {toggle strobe, opcode[2:0], arg[3:0]}
//             data     - TLOAD operand
//             irq_src  - external interrupt requests (async, rising edge)
//             inter    - registered interrupt to CPU
//             stat     - {ack_tog, inter, running, auto, pending[3:0]}
//             vec      - lowest pending&mask index (0..3) or 8'hFF
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_irq_timer #(
    parameter int PRESCALE = 50,
    parameter int PRESC_W  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd,
    input  logic [7:0] data,
    input  logic [2:0] irq_src,
    output logic       inter,
    output logic [7:0] stat,
    output logic [7:0] vec
);

    localparam logic [2:0] c_op_mask  = 3'd1;
    localparam logic [2:0] c_op_ack   = 3'd2;
    localparam logic [2:0] c_op_tload = 3'd3;
    localparam logic [2:0] c_op_tstop = 3'd4;

    localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(PRESCALE - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         r_sync3;
    logic               r_tog;
    logic [3:0]         r_mask;
    logic [3:0]         r_pend;
    logic               r_run;
    logic               r_auto;
    logic [7:0]         r_count;
    logic [7:0]         r_reload;
    logic [PRESC_W-1:0] r_presc;
    logic               r_inter;
    logic [7:0]         r_vec;
    logic [6:0]         r_stat_lo;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic       w_exec;
    logic [2:0] w_op;
    logic [3:0] w_arg;
    logic [2:0] w_rise;
    logic       w_tick;
    logic       w_expire;
    logic [3:0] w_ack;
    logic [3:0] w_set;
    logic [3:0] w_pend_nxt;
    logic [3:0] w_active;
    logic [7:0] w_vec_nxt;

    // A command runs only on the edge where the strobe differs from the
    // last acknowledged toggle, so a held cmd byte executes once.
    assign w_exec   = cmd[7] ^ r_tog;
    assign w_op     = cmd[6:4];
    assign w_arg    = cmd[3:0];

    // Third flop holds the previous synchronised level for edge detection.
    assign w_rise   = r_sync2 & ~r_sync3;

    assign w_tick   = r_run && (r_presc == c_presc_last);
    assign w_expire = w_tick && (r_count == 8'd1);

    assign w_ack    = (w_exec && (w_op == c_op_ack)) ? w_arg : 4'h0;
    assign w_set    = {w_expire, w_rise};

    // Set wins over a same-cycle acknowledge.
    assign w_pend_nxt = (r_pend & ~w_ack) | w_set;

    assign w_active = r_pend & r_mask;

    // Bit 0 has highest priority: test from bit 3 down so the lowest wins.
    always_comb begin
        w_vec_nxt = 8'hFF;
        if (w_active[3]) w_vec_nxt = 8'd3;
        if (w_active[2]) w_vec_nxt = 8'd2;
        if (w_active[1]) w_vec_nxt = 8'd1;
        if (w_active[0]) w_vec_nxt = 8'd0;
    end

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_sync3 <= 3'b000;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // ------------------------------------------------------------------
    // Command handshake, mask and pending
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tog  <= 1'b0;
            r_mask <= 4'h0;
            r_pend <= 4'h0;
        end else begin
            r_tog  <= cmd[7];
            r_pend <= w_pend_nxt;
            if (w_exec && (w_op == c_op_mask)) begin
                r_mask <= w_arg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Timer. Commands are evaluated after the tick logic so that TLOAD and
    // TSTOP override a same-cycle expiry for count/running; the expiry
    // itself still reaches pending[3] through w_set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run    <= 1'b0;
            r_auto   <= 1'b0;
            r_count  <= 8'd0;
            r_reload <= 8'd0;
            r_presc  <= '0;
        end else begin
            if (r_run) begin
                if (w_tick) begin
                    r_presc <= '0;
                    if (r_count == 8'd1) begin
                        if (r_auto) begin
                            r_count <= r_reload;
                        end else begin
                            r_count <= 8'd0;
                            r_run   <= 1'b0;
                        end
                    end else if (r_count > 8'd1) begin
                        r_count <= r_count - 8'd1;
                    end
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            if (w_exec) begin
                case (w_op)
                    c_op_tload: begin
                        r_reload <= data;
                        r_count  <= data;
                        r_presc  <= '0;
                        r_auto   <= w_arg[0];
                        r_run    <= (data != 8'd0);
                    end
                    c_op_tstop: begin
                        r_run <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered CPU-facing outputs, one cycle behind pending/mask/timer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inter   <= 1'b0;
            r_vec     <= 8'hFF;
            r_stat_lo <= 7'h00;
        end else begin
            r_inter   <= |w_active;
            r_vec     <= w_vec_nxt;
            r_stat_lo <= {|w_active, r_run, r_auto, r_pend};
        end
    end

    assign inter = r_inter;
    assign vec   = r_vec;
    assign stat  = {r_tog, r_stat_lo};

endmodule

`default_nettype wire

// File: tb/tb_io_irq_timer.sv
// ============================================================================
//  Module   : tb_io_irq_timer
//  Purpose  : Self-checking bench for io_irq_timer. A reference model steps
//             on every rising edge and queues the outputs expected after that
//             edge; a monitor on the falling edge pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_irq_timer;

    localparam int P = 4;

    logic       clk;
    logic       reset;
    logic [7:0] cmd;
    logic [7:0] data;
    logic [2:0] irq_src;
    logic       inter;
    logic [7:0] stat;
    logic [7:0] vec;

    int n_checks = 0;
    int n_pass   = 0;

    io_irq_timer #(
        .PRESCALE (P),
        .PRESC_W  (6)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd),
        .data    (data),
        .irq_src (irq_src),
        .inter   (inter),
        .stat    (stat),
        .vec     (vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. The timer is tracked as "clock edges left until
    // expiry" (data * P), and edge detection as a history of sampled levels.
    // ------------------------------------------------------------------
    logic [16:0] exp_q[$];

    logic       m_tog;
    logic [3:0] m_mask;
    logic [3:0] m_pend;
    logic       m_run;
    logic       m_auto;
    int         m_reload;
    int         m_left;
    logic [2:0] m_h1, m_h2, m_h3;

    logic [3:0] m_pm;
    logic       m_ei;
    logic [7:0] m_ev;
    logic       m_exec;
    logic [2:0] m_op;
    logic [3:0] m_arg;
    logic       m_expire;
    logic [2:0] m_rise;
    logic [3:0] m_ack;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_tog    = 1'b0;
            m_mask   = 4'h0;
            m_pend   = 4'h0;
            m_run    = 1'b0;
            m_auto   = 1'b0;
            m_reload = 0;
            m_left   = 0;
            m_h1     = 3'b000;
            m_h2     = 3'b000;
            m_h3     = 3'b000;
            exp_q.delete();
        end else begin
            // Outputs after this edge reflect the state before it.
            m_pm = m_pend & m_mask;
            m_ei = |m_pm;
            m_ev = 8'hFF;
            for (int i = 3; i >= 0; i--) if (m_pm[i]) m_ev = 8'(i);
            m_exec = (cmd[7] != m_tog);
            m_op   = cmd[6:4];
            m_arg  = cmd[3:0];
            m_tog  = cmd[7];
            exp_q.push_back({m_ei, m_tog, m_ei, m_run, m_auto, m_pend, m_ev});

            // Timer
            m_expire = 1'b0;
            if (m_run) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_expire = 1'b1;
                    if (m_auto) m_left = m_reload * P;
                    else        m_run  = 1'b0;
                end
            end

            // A level first seen high at edge n-2 after low at n-3 sets pending at n.
            m_rise = m_h2 & ~m_h3;
            m_h3 = m_h2;
            m_h2 = m_h1;
            m_h1 = irq_src;

            m_ack  = (m_exec && m_op == 3'd2) ? m_arg : 4'h0;
            m_pend = (m_pend & ~m_ack) | {m_expire, m_rise};

            if (m_exec) begin
                case (m_op)
                    3'd1: m_mask = m_arg;
                    3'd3: begin
                        m_reload = int'(data);
                        m_left   = int'(data) * P;
                        m_auto   = m_arg[0];
                        m_run    = (data != 8'd0);
                    end
                    3'd4: m_run = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [16:0] mon_exp;

    always @(negedge clk) begin
        if (reset) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty at %0t: got inter=%b stat=%h vec=%h, required a queued expectation",
                         $time, inter, stat, vec);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({inter, stat, vec} === mon_exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs at %0t: got inter=%b stat=%h vec=%h, required inter=%b stat=%h vec=%h",
                             $time, inter, stat, vec, mon_exp[16], mon_exp[15:8], mon_exp[7:0]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] arg, input logic [7:0] dat);
        cmd  = {~cmd[7], op, arg};
        data = dat;
        tick();
    endtask

    task automatic check_reset_outputs(input string name);
        #1;
        n_checks++;
        if (inter === 1'b0 && stat === 8'h00 && vec === 8'hFF) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got inter=%b stat=%h vec=%h, required inter=0 stat=00 vec=ff",
                     name, inter, stat, vec);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset   = 1'b0;
        cmd     = 8'h00;
        data    = 8'h00;
        irq_src = 3'b000;
        repeat (3) tick();
        check_reset_outputs("reset_initial");
        reset = 1'b1;
        repeat (20) tick();

        // MASK 1, pulse source 0, then ACK 1.
        send(3'd1, 4'h1, 8'h00);
        irq_src = 3'b001;
        repeat (3) tick();
        irq_src = 3'b000;
        repeat (5) tick();
        send(3'd2, 4'h1, 8'h00);
        repeat (4) tick();

        // Mask 1110, sources 0 and 2 together, then unmask all.
        send(3'd1, 4'hE, 8'h00);
        irq_src = 3'b101;
        repeat (6) tick();
        irq_src = 3'b000;
        send(3'd1, 4'hF, 8'h00);
        repeat (3) tick();
        send(3'd2, 4'hF, 8'h00);
        repeat (3) tick();

        // Auto-reload timer, period 3 * P.
        send(3'd1, 4'h8, 8'h00);
        send(3'd3, 4'h1, 8'd3);
        repeat (30) tick();
        send(3'd2, 4'h8, 8'h00);
        repeat (30) tick();
        // One-shot timer.
        send(3'd3, 4'h0, 8'd3);
        repeat (20) tick();
        send(3'd2, 4'h8, 8'h00);
        repeat (3) tick();

        // ACK 2 on the very edge source 1 sets pending[1].
        send(3'd1, 4'h2, 8'h00);
        irq_src = 3'b010;
        tick();
        tick();
        send(3'd2, 4'h2, 8'h00);
        irq_src = 3'b000;
        repeat (5) tick();
        send(3'd2, 4'h2, 8'h00);
        repeat (3) tick();

        // ACK 8 on the very edge the timer expires.
        send(3'd1, 4'h8, 8'h00);
        send(3'd3, 4'h0, 8'd3);
        repeat (11) tick();
        send(3'd2, 4'h8, 8'h00);
        repeat (5) tick();

        // TLOAD colliding with a running timer and TLOAD with zero data.
        send(3'd3, 4'h1, 8'd2);
        repeat (5) tick();
        send(3'd3, 4'h1, 8'd1);
        repeat (9) tick();
        send(3'd3, 4'h1, 8'd0);
        repeat (4) tick();
        send(3'd4, 4'h0, 8'h00);
        send(3'd5, 4'h3, 8'h00);
        repeat (3) tick();

        // Reset mid-operation, then a stale toggled command.
        send(3'd1, 4'hF, 8'h00);
        send(3'd3, 4'h1, 8'd3);
        irq_src = 3'b001;
        repeat (6) tick();
        irq_src = 3'b000;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_outputs("reset_async_midrun");
        cmd = 8'h91;
        repeat (2) tick();
        check_reset_outputs("reset_held");
        reset = 1'b1;
        repeat (10) tick();

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) irq_src[b] = ~irq_src[b];
            end
            if (i == 1200) begin
                reset = 1'b0;
                check_reset_outputs("reset_random");
                tick();
                reset = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) begin
                send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                     8'($urandom_range(0, 5)));
            end else begin
                tick();
            end
        end
        irq_src = 3'b000;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
